// File: rtl/ysyx_22050058_pipe_stage.sv
// Pipeline stage register with valid/ready handshake between core stages.
// SKID=1 adds a second entry so that in_ready comes only from registers.
// With SKID=0 the skid entry never fills: in_ready then only allows a load
// into a full main register when the head leaves in the same cycle.
module ysyx_22050058_pipe_stage #(
  parameter int                 DATA_W      = 160,
  parameter logic [DATA_W-1:0]  RST_DATA    = '0,
  parameter logic [DATA_W-1:0]  BUBBLE_DATA = '0,
  parameter bit                 CLR_BUBBLE  = 1'b1,
  parameter bit                 SKID        = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        count
);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  // Upstream acceptance: registered-only in skid mode, pass-through otherwise.
  always_comb begin
    in_ready = 1'b0;
    if (SKID) begin
      in_ready = !skid_valid && rst && !flush;
    end else begin
      in_ready = (!out_valid || out_ready) && rst && !flush;
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign count    = {1'b0, out_valid} + {1'b0, skid_valid};

  // Main and skid entry update; flush wins over every handshake event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= RST_DATA;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      if (CLR_BUBBLE) out_data <= BUBBLE_DATA;
    end else if (out_fire) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_data <= in_data;
      end else begin
        out_valid <= 1'b0;
        if (CLR_BUBBLE) out_data <= BUBBLE_DATA;
      end
    end else if (in_fire) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050058_pipe_stage.sv
// Directed and randomized checks for ysyx_22050058_pipe_stage.
module tb_ysyx_22050058_pipe_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;

  // Skid-mode instance with bubble clearing, and a non-clearing twin
  logic         in_valid, out_ready;
  logic [159:0] in_data;
  logic         in_ready, out_valid;
  logic [159:0] out_data;
  logic [1:0]   count;
  logic         nc_in_ready, nc_out_valid;
  logic [159:0] nc_out_data;
  logic [1:0]   nc_count;

  // Pass-through instance
  logic         ns_in_valid, ns_out_ready;
  logic [31:0]  ns_in_data;
  logic         ns_in_ready, ns_out_valid;
  logic [31:0]  ns_out_data;
  logic [1:0]   ns_count;

  int n_cmp = 0;
  int n_err = 0;
  int m_sent, m_recv, s_sent, s_recv;

  always #5 clk = ~clk;

  ysyx_22050058_pipe_stage u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .count(count)
  );

  ysyx_22050058_pipe_stage #(.CLR_BUBBLE(1'b0)) u_nc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nc_in_ready),
    .in_data(in_data), .out_valid(nc_out_valid), .out_ready(out_ready),
    .out_data(nc_out_data), .flush(flush), .count(nc_count)
  );

  ysyx_22050058_pipe_stage #(.DATA_W(32), .SKID(1'b0)) u_ns (
    .clk(clk), .rst(rst), .in_valid(ns_in_valid), .in_ready(ns_in_ready),
    .in_data(ns_in_data), .out_valid(ns_out_valid), .out_ready(ns_out_ready),
    .out_data(ns_out_data), .flush(1'b0), .count(ns_count)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    ns_in_valid = 1'b0; ns_out_ready = 1'b0; ns_in_data = '0;
    #1;
    check("rst_in_ready", 160'(in_ready), 160'd0);
    check("rst_out_valid", 160'(out_valid), 160'd0);
    check("rst_count", 160'(count), 160'd0);
    check("rst_out_data", out_data, 160'd0);
    step(); step();
    rst = 1'b1;
    #1;
    check("rel_in_ready", 160'(in_ready), 160'd1);

    // Streaming at full rate
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 160'(i);
      step();
      check("stream_data", out_data, 160'(i));
      check("stream_valid", 160'(out_valid), 160'd1);
      check("stream_count", 160'(count), 160'd1);
      check("stream_in_ready", 160'(in_ready), 160'd1);
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", 160'(out_valid), 160'd0);
    check("drain_bubble", out_data, 160'd0);

    // Back-pressure into the skid entry
    in_valid = 1'b1; in_data = 160'hA;
    step();
    check("bp_a", out_data, 160'hA);
    out_ready = 1'b0; in_data = 160'hB;
    #1;
    check("bp_ready_b", 160'(in_ready), 160'd1);
    step();
    check("bp_count2", 160'(count), 160'd2);
    check("bp_ready0", 160'(in_ready), 160'd0);
    check("bp_hold_a", out_data, 160'hA);
    in_data = 160'hC;
    step();
    check("bp_c_held", 160'(count), 160'd2);
    check("bp_hold_a2", out_data, 160'hA);
    out_ready = 1'b1;
    step();
    check("bp_b", out_data, 160'hB);
    check("bp_count1", 160'(count), 160'd1);
    check("bp_ready1", 160'(in_ready), 160'd1);
    step();
    check("bp_c", out_data, 160'hC);
    in_valid = 1'b0;
    step();
    check("bp_empty", 160'(out_valid), 160'd0);

    // Flush with both entries held and upstream offering 0xF
    out_ready = 1'b0; in_valid = 1'b1; in_data = 160'h1;
    step();
    in_data = 160'h2;
    step();
    check("fl_count2", 160'(count), 160'd2);
    flush = 1'b1; in_data = 160'hF;
    #1;
    check("fl_in_ready", 160'(in_ready), 160'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", 160'(out_valid), 160'd0);
    check("fl_count", 160'(count), 160'd0);
    check("fl_bubble", out_data, 160'd0);
    check("fl_nc_keep", nc_out_data, 160'h1);
    check("fl_nc_count", 160'(nc_count), 160'd0);
    step();
    check("fl_no_f", 160'(out_valid), 160'd0);

    // Bubble clearing versus hold on empty
    out_ready = 1'b1; in_valid = 1'b1; in_data = 160'h5;
    step();
    check("bub_5", out_data, 160'h5);
    check("bub_nc_5", nc_out_data, 160'h5);
    in_valid = 1'b0;
    step();
    check("bub_valid", 160'(out_valid), 160'd0);
    check("bub_clear", out_data, 160'd0);
    check("bub_nc_valid", 160'(nc_out_valid), 160'd0);
    check("bub_nc_hold", nc_out_data, 160'h5);

    // Asynchronous reset with the stage full
    out_ready = 1'b0; in_valid = 1'b1; in_data = 160'h7;
    step();
    in_data = 160'h8;
    step();
    check("ar_count2", 160'(count), 160'd2);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", 160'(out_valid), 160'd0);
    check("ar_count", 160'(count), 160'd0);
    check("ar_data", out_data, 160'd0);
    check("ar_in_ready", 160'(in_ready), 160'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("ar_release", 160'(in_ready), 160'd1);
    check("ar_count_rel", 160'(count), 160'd0);

    // Pass-through mode: replace the head in the same cycle
    ns_in_valid = 1'b1; ns_out_ready = 1'b1; ns_in_data = 32'h3;
    step();
    check("ns_3", 160'(ns_out_data), 160'h3);
    ns_in_data = 32'h4;
    #1;
    check("ns_ready_same", 160'(ns_in_ready), 160'd1);
    step();
    check("ns_4", 160'(ns_out_data), 160'h4);
    check("ns_count", 160'(ns_count), 160'd1);
    ns_out_ready = 1'b0;
    #1;
    check("ns_ready_bp", 160'(ns_in_ready), 160'd0);
    ns_in_valid = 1'b0;
    step();
    check("ns_hold", 160'(ns_out_data), 160'h4);
    check("ns_hold_valid", 160'(ns_out_valid), 160'd1);

    // Fresh start, then a random valid/ready run on both modes
    rst = 1'b0;
    step();
    rst = 1'b1;
    m_sent = 0; m_recv = 0; s_sent = 0; s_recv = 0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      in_valid     = 1'($urandom_range(0, 1));
      out_ready    = 1'($urandom_range(0, 1));
      in_data      = 160'(m_sent + 1);
      ns_in_valid  = 1'($urandom_range(0, 1));
      ns_out_ready = 1'($urandom_range(0, 1));
      ns_in_data   = 32'(s_sent + 1);
      @(negedge clk);
      check("rnd_count", 160'(count), 160'(m_sent - m_recv));
      check("rnd_in_ready", 160'(in_ready), 160'((m_sent - m_recv) < 2));
      check("rnd_ns_count", 160'(ns_count), 160'(s_sent - s_recv));
      check("rnd_ns_in_ready", 160'(ns_in_ready),
            160'(((s_sent - s_recv) == 0) || ns_out_ready));
      if (out_valid && out_ready) begin
        check("rnd_order", out_data, 160'(m_recv + 1));
        m_recv++;
      end
      if (in_valid && in_ready) m_sent++;
      if (ns_out_valid && ns_out_ready) begin
        check("rnd_ns_order", 160'(ns_out_data), 160'(s_recv + 1));
        s_recv++;
      end
      if (ns_in_valid && ns_in_ready) s_sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; ns_in_valid = 1'b0; ns_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) m_recv++;
      if (ns_out_valid) s_recv++;
    end
    check("rnd_total", 160'(m_recv), 160'(m_sent));
    check("rnd_ns_total", 160'(s_recv), 160'(s_sent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22050058_pipe_stage.md
# ysyx_22050058_pipe_stage

Parametrised pipeline stage register that replaces the fixed-width stall/flush stage registers between the IF, ID, EX, MEM and WB stages. Each stage boundary uses a valid/ready handshake with configurable payload width. An optional 2-entry skid buffer cuts the combinational ready path. The stage also provides flush, configurable bubble clearing and an occupancy output for the control block.

## Interface
- `DATA_W`, 160: payload width (pc 64 + dnpc 64 + inst 32 for the IF/ID instance).
- `RST_DATA`, 0: `out_data` value during and after reset.
- `BUBBLE_DATA`, 0: value loaded into `out_data` when the stage empties, if `CLR_BUBBLE`=1.
- `CLR_BUBBLE`, 1: 1 loads `BUBBLE_DATA` on empty/flush; 0 leaves `out_data` unchanged.
- `SKID`, 1: 1 selects a 2-entry skid buffer with registered `in_ready`; 0 selects a 1-entry register with pass-through `in_ready`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream presents `in_data`.
- `in_ready`  out  1  stage accepts `in_data` this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  `out_data` holds a live entry.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  DATA_W  head payload, driven directly from a register.
- `flush`  in  1  discard all held entries.
- `count`  out  2  entries held: 0..2, or 0..1 when `SKID`=0.

## Operation
- Input fire: `in_valid && in_ready`. Output fire: `out_valid && out_ready`.
- Storage: a main register (`out_data`/`out_valid`) plus, when `SKID`=1, a skid register (`skid_data`/`skid_valid`).
- `SKID`=1 behaviour:
  - `in_ready` = !`skid_valid` && `rst` && !`flush`.
  - Output fire with skid full: main <= skid, skid empties. No input can be accepted in this case.
  - Output fire with skid empty: main <= `in_data` if input fires; otherwise main empties.
  - No output fire, input fires, main empty: main <= `in_data`.
  - No output fire, input fires, main full: skid <= `in_data`.
- `SKID`=0 behaviour:
  - `in_ready` = (!`out_valid` || `out_ready`) && `rst` && !`flush`.
  - Main loads on input fire, empties on output fire without input fire.
- Ordering: FIFO. Entries never reorder, duplicate or drop except on flush.
- Flush:
  - Next edge clears `out_valid` and `skid_valid`.
  - `out_data` <= `BUBBLE_DATA` if `CLR_BUBBLE`=1.
  - `in_ready` is 0 during the flush cycle, so nothing is accepted.
  - An output fire in the flush cycle counts as completed.
  - Flush has priority over every other event.
- Empty transition: when main empties and `CLR_BUBBLE`=1, `out_data` <= `BUBBLE_DATA` (zero inst = bubble); otherwise `out_data` holds its last value.
- Hold: `out_valid` && !`out_ready` keeps `out_data`/`out_valid` stable until fire. This replaces the old stall hold.
- `count` = `out_valid` + `skid_valid`, registered-derived with no combinational input path.

## Timing
- Reset (`rst`=0, asynchronous assert, synchronous-to-`clk` deassert expected):
  - `out_valid`=0, `skid_valid`=0, `out_data`=`RST_DATA`, `count`=0.
  - `in_ready`=0 while `rst`=0.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: input fire at edge N makes `out_valid`=1 with that data after edge N (1 cycle).
- Throughput: 1 entry/cycle sustained with `out_ready`=1, both modes.
- `SKID`=1: `in_ready` depends only on registers and `flush`/`rst`. There is no path from `out_ready` to `in_ready`.
- Back-pressure, `SKID`=1: after `out_ready` drops, at most 1 further entry is accepted (into skid), then `in_ready`=0. `in_ready` returns to 1 the cycle after the skid drains.
- Full (`count`=2) plus `out_ready`=1: next edge gives `count`=1, then `in_ready`=1.

## Test plan
- Reset: hold `rst`=0 mid-stream with `count`=2 -> immediately `out_valid`=0, `count`=0, `out_data`=0, `in_ready`=0. Release -> `in_ready`=1.
- Streaming, `SKID`=1: feed 0x1..0x8 with `in_valid`=1, `out_ready`=1 -> `out_data` 0x1..0x8 on consecutive cycles, 1-cycle latency, `count`=1 throughout.
- Back-pressure: stream 0xA,0xB,0xC and drop `out_ready` while 0xA is on the output -> 0xB goes to skid, `in_ready`=0, 0xC is held upstream. Raise `out_ready` -> output order 0xA,0xB,0xC with no loss.
- Flush with `count`=2 while `in_valid`=1 (data 0xF) -> `in_ready`=0 that cycle. Next cycle `out_valid`=0, `count`=0, `out_data`=`BUBBLE_DATA`, and 0xF is not accepted.
- Bubble: single entry 0x5 drained, `in_valid`=0 -> `out_valid`=0, `out_data`=0 with `CLR_BUBBLE`=1. Repeat with `CLR_BUBBLE`=0 -> `out_data` stays 0x5.
- `SKID`=0 with `out_valid`=1, `out_ready`=1, `in_valid`=1 -> `in_ready`=1 in the same cycle, entry replaced, `count` stays 1. Random valid/ready run of 10k cycles -> scoreboard shows in-order delivery, no duplicates.
